// File: rtl/dds_sweep.sv
`default_nettype none
// =============================================================================
// dds_sweep : quadrature DDS with CW / single / repeating / triangle chirp engine
// Optional DDS_PHASE_DITHER_EN : LFSR dither added to the accumulator before truncation
// Rev 1.0
// =============================================================================
module dds_sweep #(
    parameter int pFR_W   = 32,
    parameter int pPH_W   = 15,
    parameter int pDDS_W  = 14,
    parameter int pSTEP_W = 24,
    parameter int pCNT_W  = 20
) (
    input  logic                 iclk,
    input  logic                 ireset_n,
    input  logic                 iclkena,
    input  logic                 icfg_val,
    output logic                 ocfg_rdy,
    input  logic [1:0]           icfg_mode,
    input  logic [pFR_W-1:0]     icfg_fstart,
    input  logic [pSTEP_W-1:0]   icfg_fstep,
    input  logic [pCNT_W-1:0]    icfg_len,
    input  logic [pPH_W-1:0]     iph_sin,
    input  logic [pPH_W-1:0]     iph_cos,
    input  logic                 isync,
    input  logic                 istop,
    output logic [pDDS_W-1:0]    osin,
    output logic [pDDS_W-1:0]    ocos,
    output logic                 oval,
    output logic [pFR_W-1:0]     ofreq,
    output logic                 obusy,
    output logic                 oeos
);

    localparam int              c_TW = pPH_W - 2;
    localparam int              c_N  = 1 << c_TW;
    localparam int              c_A  = (1 << (pDDS_W - 1)) - 1;
    localparam real             c_PI = 3.14159265358979323846;
    localparam logic [pPH_W-2:0] c_NV = {1'b1, {c_TW{1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_t;

    state_t              r_state, w_state_nx;
    logic [1:0]          r_mode;
    logic [pFR_W-1:0]    r_fstart, r_freq, r_acc, w_acc_t, w_step_x;
    logic [pSTEP_W-1:0]  r_step;
    logic [pCNT_W-1:0]   r_len, r_cnt;
    logic                r_dir_dn, r_restart, r_eos;
    logic                w_accept, w_last;
    logic [6:0]          r_vsr;

    assign ocfg_rdy = (r_state != S_RUN);
    assign obusy    = (r_state == S_RUN);
    assign ofreq    = r_freq;
    assign oeos     = r_eos;
    assign oval     = r_vsr[6];
    assign w_step_x = {{(pFR_W-pSTEP_W){r_step[pSTEP_W-1]}}, r_step};
    assign w_accept = icfg_val & ocfg_rdy & ~istop;

    always_comb begin
        w_last     = (r_state == S_RUN) && !r_restart && (r_cnt == r_len - pCNT_W'(1));
        w_state_nx = r_state;
        if (istop)
            w_state_nx = S_IDLE;
        else if (w_accept)
            w_state_nx = (icfg_mode == 2'b00 || icfg_len == '0) ? S_HOLD : S_RUN;
        else if (w_last && r_mode == 2'b01)
            w_state_nx = S_HOLD;
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n)
            r_state <= S_IDLE;
        else if (iclkena)
            r_state <= w_state_nx;
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_mode <= '0; r_fstart <= '0; r_step <= '0; r_len <= '0;
            r_freq <= '0; r_acc <= '0; r_cnt <= '0;
            r_dir_dn <= 1'b0; r_restart <= 1'b0; r_eos <= 1'b0;
            r_vsr <= '0;
        end else if (iclkena) begin
            r_eos <= 1'b0;
            r_vsr <= {r_vsr[5:0], r_state != S_IDLE};
            if (istop) begin
                r_freq <= '0;
                r_acc  <= '0;
            end else if (w_accept) begin
                r_mode    <= icfg_mode;
                r_fstart  <= icfg_fstart;
                r_step    <= icfg_fstep;
                r_len     <= icfg_len;
                r_freq    <= icfg_fstart;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_dir_dn  <= 1'b0;
                r_restart <= 1'b0;
            end else begin
                r_acc <= (isync || r_state == S_IDLE) ? '0 : r_acc + r_freq;
                if (r_state == S_RUN) begin
                    // repeating mode spends one cycle jumping back to fstart after each sweep
                    if (r_restart) begin
                        r_freq    <= r_fstart;
                        r_cnt     <= '0;
                        r_restart <= 1'b0;
                    end else begin
                        r_freq <= r_dir_dn ? r_freq - w_step_x : r_freq + w_step_x;
                        r_cnt  <= r_cnt + pCNT_W'(1);
                        if (w_last) begin
                            r_eos <= 1'b1;
                            r_cnt <= '0;
                            if (r_mode == 2'b10) r_restart <= 1'b1;
                            if (r_mode == 2'b11) r_dir_dn  <= ~r_dir_dn;
                        end
                    end
                end
            end
        end
    end

`ifdef DDS_PHASE_DITHER_EN
    localparam logic [31:0] c_DMASK = (32'h1 << (pFR_W - pPH_W)) - 32'h1;
    logic [31:0] r_lfsr;

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n)
            r_lfsr <= 32'h1;
        else if (iclkena)
            r_lfsr <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
    end
    assign w_acc_t = r_acc + pFR_W'(r_lfsr & c_DMASK);
`else
    assign w_acc_t = r_acc;
`endif

    // Quarter-wave table, constant-folded at elaboration
    logic [pDDS_W-2:0] w_tab [c_N];
    for (genvar k = 0; k < c_N; k++) begin : g_rom
        localparam int c_V = $rtoi(real'(c_A) * $sin(c_PI / 2.0 * real'(k) / real'(c_N)) + 0.5);
        assign w_tab[k] = (pDDS_W-1)'(c_V);
    end

    // Returns {negate, magnitude 0..N}; cosine is sine advanced a quarter turn
    function automatic logic [pPH_W-1:0] fold(input logic [pPH_W-1:0] ph, input logic quad);
        logic [1:0]       q;
        logic [pPH_W-2:0] a;
        q = ph[pPH_W-1 -: 2] + {1'b0, quad};
        a = {1'b0, ph[pPH_W-3:0]};
        return {q[1], q[0] ? (c_NV - a) : a};
    endfunction

    logic [pPH_W-1:0]  w_off [2];
    logic [pPH_W-1:0]  r_tap;
    logic [pPH_W-1:0]  r_ph [2];
    logic [pPH_W-1:0]  r_fd [2];
    logic [c_TW-1:0]   r_ad [2];
    logic [pDDS_W-2:0] r_r4 [2];
    logic [pDDS_W-2:0] r_r5 [2];
    logic [2:0]        r_ng [2];
    logic [pDDS_W-1:0] r_out [2];

    assign w_off[0] = iph_sin;
    assign w_off[1] = iph_cos;
    assign osin     = r_out[0];
    assign ocos     = r_out[1];

    // The accumulator tap stage keeps the first sample aligned with the 7-deep valid flag
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_tap <= '0;
            for (int i = 0; i < 2; i++) begin
                r_ph[i] <= '0; r_fd[i] <= '0; r_ad[i] <= '0;
                r_r4[i] <= '0; r_r5[i] <= '0; r_ng[i] <= '0; r_out[i] <= '0;
            end
        end else if (iclkena) begin
            r_tap <= pPH_W'(w_acc_t >> (pFR_W - pPH_W));
            for (int i = 0; i < 2; i++) begin
                r_ph[i]  <= r_tap + w_off[i];
                r_fd[i]  <= fold(r_ph[i], i[0]);
                r_ad[i]  <= (r_fd[i][pPH_W-2:0] == c_NV) ? {c_TW{1'b1}} : r_fd[i][c_TW-1:0];
                r_ng[i]  <= {r_ng[i][1:0], r_fd[i][pPH_W-1]};
                r_r4[i]  <= w_tab[r_ad[i]];
                r_r5[i]  <= r_r4[i];
                r_out[i] <= r_ng[i][2] ? pDDS_W'(0) - {1'b0, r_r5[i]} : {1'b0, r_r5[i]};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep.sv
`timescale 1ns/1ps
`default_nettype none
// tb_dds_sweep : randomized + directed bench with a behavioural sweep/tone reference model
module tb_dds_sweep;
    localparam int FR = 32, PH = 15, DW = 14, SW = 24, CW = 20;
    localparam int N  = 1 << (PH - 2);
    localparam int A  = (1 << (DW - 1)) - 1;

    logic iclk = 1'b0, ireset_n = 1'b0, iclkena = 1'b1, icfg_val = 1'b0;
    logic ocfg_rdy, oval, obusy, oeos;
    logic [1:0] icfg_mode = '0;
    logic [FR-1:0] icfg_fstart = '0;
    logic [SW-1:0] icfg_fstep = '0;
    logic [CW-1:0] icfg_len = '0;
    logic [PH-1:0] iph_sin = '0, iph_cos = '0;
    logic isync = 1'b0, istop = 1'b0;
    logic [DW-1:0] osin, ocos;
    logic [FR-1:0] ofreq;

    dds_sweep #(.pFR_W(FR), .pPH_W(PH), .pDDS_W(DW), .pSTEP_W(SW), .pCNT_W(CW)) dut (
        .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .icfg_val(icfg_val),
        .ocfg_rdy(ocfg_rdy), .icfg_mode(icfg_mode), .icfg_fstart(icfg_fstart),
        .icfg_fstep(icfg_fstep), .icfg_len(icfg_len), .iph_sin(iph_sin), .iph_cos(iph_cos),
        .isync(isync), .istop(istop), .osin(osin), .ocos(ocos), .oval(oval),
        .ofreq(ofreq), .obusy(obusy), .oeos(oeos)
    );

    always #5 iclk = ~iclk;

    int total = 0, bad = 0;
    int tab [N];
    // model state: 0 idle, 1 run, 2 hold; freq = fstart + pos*step
    int m_st, m_mode, m_step, m_len, m_pos, m_k;
    bit m_up, m_restart, m_eos;
    logic [31:0] m_freq, m_acc, m_fstart;
    logic [31:0] h_acc [16];
    int          h_st  [16];
    logic [14:0] h_os [16], h_oc [16];
    int n = 16;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic int sv(input logic [14:0] ph);
        int q, a, m;
        q = int'(ph[14:13]);
        a = int'(ph[12:0]);
        m = (q % 2 == 1) ? N - a : a;
        if (m > N - 1) m = N - 1;
        return (q >= 2) ? -tab[m] : tab[m];
    endfunction

    task automatic model_reset();
        m_st = 0; m_freq = 0; m_acc = 0; m_eos = 0; m_restart = 0; m_pos = 0; m_k = 0; m_up = 1;
        for (int i = 0; i < 16; i++) begin h_st[i] = 0; h_acc[i] = 0; h_os[i] = 0; h_oc[i] = 0; end
    endtask

    task automatic model_edge();
        bit rdy;
        if (!iclkena) return;
        rdy = (m_st != 1);
        n++;
        m_eos = 0;
        if (istop) begin
            m_st = 0; m_freq = 0; m_acc = 0;
        end else if (icfg_val && rdy) begin
            m_mode = int'(icfg_mode); m_fstart = icfg_fstart; m_step = int'($signed(icfg_fstep));
            m_len = int'(icfg_len); m_pos = 0; m_k = 0; m_up = 1; m_restart = 0;
            m_acc = 0; m_freq = icfg_fstart;
            m_st = (icfg_mode == 2'b00 || icfg_len == '0) ? 2 : 1;
        end else begin
            if (isync || m_st == 0) m_acc = 0; else m_acc = m_acc + m_freq;
            if (m_st == 1) begin
                if (m_restart) begin
                    m_restart = 0; m_pos = 0; m_k = 0;
                end else begin
                    m_pos += m_up ? 1 : -1;
                    m_k++;
                    if (m_k == m_len) begin
                        m_eos = 1; m_k = 0;
                        case (m_mode)
                            1: m_st = 2;
                            2: m_restart = 1;
                            3: m_up = !m_up;
                            default: ;
                        endcase
                    end
                end
                m_freq = m_fstart + 32'(m_pos * m_step);
            end
        end
        h_acc[n % 16] = m_acc; h_st[n % 16] = m_st;
        h_os[n % 16] = iph_sin; h_oc[n % 16] = iph_cos;
    endtask

    task automatic check_outputs();
        int i7, i5;
        bit v;
        logic [14:0] ps, pc;
        i7 = (n + 9) % 16;
        i5 = (n + 11) % 16;
        v  = (h_st[i7] != 0);
        check("ofreq", ofreq, m_freq);
        check("oval", oval, v);
        check("obusy", obusy, m_st == 1);
        check("oeos", oeos, m_eos);
        check("ocfg_rdy", ocfg_rdy, m_st != 1);
        if (v) begin
            ps = h_acc[i7][31:17] + h_os[i5];
            pc = h_acc[i7][31:17] + h_oc[i5] + 15'(N);
            check("osin", $signed(osin), sv(ps));
            check("ocos", $signed(ocos), sv(pc));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge iclk);
        #1;
        check_outputs();
    endtask

    task automatic cfg(input logic [1:0] md, input logic [31:0] fs, input logic [23:0] st, input int len);
        icfg_val = 1'b1; icfg_mode = md; icfg_fstart = fs; icfg_fstep = st; icfg_len = CW'(len);
        tick();
        icfg_val = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_osin"}, osin, 0);
        check({tag, "_ocos"}, ocos, 0);
        check({tag, "_ofreq"}, ofreq, 0);
        check({tag, "_oval"}, oval, 0);
        check({tag, "_oeos"}, oeos, 0);
        check({tag, "_obusy"}, obusy, 0);
        check({tag, "_rdy"}, ocfg_rdy, 1);
    endtask

    int cw_s[4], cw_c[4];
    int sgl_f[6] = '{1000, 2000, 3000, 4000, 4000, 4000};
    int tri_f[10] = '{10, 20, 30, 20, 10, 0, 10, 20, 30, 20};
    logic [31:0] f_saved;

    initial begin
        for (int k = 0; k < N; k++)
            tab[k] = $rtoi(real'(A) * $sin(3.14159265358979323846 / 2.0 * real'(k) / real'(N)) + 0.5);
        cw_s = '{0, tab[N-1], 0, -tab[N-1]};
        cw_c = '{tab[N-1], 0, -tab[N-1], 0};
        model_reset();
        #1;
        check_reset_outputs("por");
        @(negedge iclk); ireset_n = 1'b1;
        repeat (3) tick();

        // CW at fs/4: first valid sample 7 edges after accept
        cfg(2'b00, 32'h4000_0000, 24'd0, 0);
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 6) check("cw_oval_pre", oval, 0);
            if (i >= 7) begin
                check("cw_oval", oval, 1);
                check("cw_sin", $signed(osin), cw_s[(i - 7) % 4]);
                check("cw_cos", $signed(ocos), cw_c[(i - 7) % 4]);
            end
        end

        // single up-sweep ends in HOLD at the final frequency
        cfg(2'b01, 32'd0, 24'd1000, 4);
        check("sgl_f0", ofreq, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sgl_freq", ofreq, sgl_f[i]);
            check("sgl_eos", oeos, i == 3);
            check("sgl_rdy", ocfg_rdy, i >= 3);
        end

        // triangle
        cfg(2'b11, 32'd0, 24'd10, 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("tri_freq", ofreq, tri_f[i]);
            check("tri_eos", oeos, i == 2 || i == 5 || i == 8);
            check("tri_busy", obusy, 1);
        end

        // stop beats a simultaneous configuration
        istop = 1'b1;
        cfg(2'b00, 32'd12345, 24'd0, 0);
        istop = 1'b0;
        check("stop_freq", ofreq, 0);
        check("stop_busy", obusy, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("stop_oval", oval, k < 7);
        end

        // clock-enable freeze mid-sweep, then phase sync
        iph_sin = 15'd1000; iph_cos = 15'd3000;
        cfg(2'b10, 32'd5000, 24'hFFFED4, 5);
        repeat (4) tick();
        f_saved = m_freq;
        iclkena = 1'b0;
        repeat (5) begin
            tick();
            check("frz_freq", ofreq, f_saved);
        end
        iclkena = 1'b1;
        repeat (6) tick();
        isync = 1'b1; tick(); isync = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 7) begin
                check("sync_sin", $signed(osin), sv(15'd1000));
                check("sync_cos", $signed(ocos), sv(15'd3000 + 15'(N)));
            end
        end

        // asynchronous reset mid-run
        cfg(2'b10, 32'h0010_0000, 24'd777, 100);
        repeat (10) tick();
        #2 ireset_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_reset();
        repeat (2) @(negedge iclk);
        ireset_n = 1'b1;
        repeat (3) tick();

        // randomized traffic
        for (int it = 0; it < 1500; it++) begin
            iclkena     = ($urandom % 10) != 0;
            icfg_val    = ($urandom % 8) == 0;
            icfg_mode   = 2'($urandom);
            icfg_fstart = $urandom;
            icfg_fstep  = 24'($urandom);
            icfg_len    = CW'($urandom % 7);
            isync       = ($urandom % 40) == 0;
            istop       = ($urandom % 60) == 0;
            if ($urandom % 100 == 0) begin
                iph_sin = 15'($urandom);
                iph_cos = 15'($urandom);
            end
            tick();
        end
        icfg_val = 1'b0; isync = 1'b0; istop = 1'b0; iclkena = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
